mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Initiator side of the data-memory interface. Accepts load/store requests from the MIPS datapath over a req/ready handshake and drives the word-wide synchronous-write, asynchronous-read data memory. Handles byte and halfword accesses: loads are extracted and extended, stores are done as read-modify-write.
It returns a one-cycle response pulse with load data.

Parameters:
ADDR_WIDTH, 32, byte address width from datapath
MEM_ADDR_WIDTH, 30, word address width driven to memory (ADDR_WIDTH-2)
DATA_WIDTH, 32, word width; fixed at 32 (four byte lanes)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  request valid; sampled only while ready=1
ready  output  1  unit idle, request accepted on clk edge when req&ready
we  input  1  1=store, 0=load
size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
uns  input  1  load zero-extend when 1, sign-extend when 0
addr  input  ADDR_WIDTH  byte address
wdata  input  DATA_WIDTH  store data, right-justified for sub-word
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  misaligned access flag, valid with resp_valid
rdata  output  DATA_WIDTH  load result, valid with resp_valid
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  MEM_ADDR_WIDTH  word address = addr[ADDR_WIDTH-1:2]
mem_di  output  DATA_WIDTH  write word
mem_do  input  DATA_WIDTH  memory read word (combinational from mem_addr)

Behaviour:
- Reset (async, rst_n=0): state IDLE; resp_valid=0, resp_err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_di=0; latched request cleared. ready=1 in IDLE.
- Reset mid-operation: mem_we/mem_en drop immediately. Pending request is discarded with no response. A write edge that has already occurred stands.
- On accept, the request fields are latched. Inputs are ignored until the unit returns to IDLE.
- Byte lanes are little-endian: byte k = word[8k+7:8k], lane = addr[1:0]. The halfword lane is addr[1].
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE, on accept:
  - load -> LOAD
  - word store -> WRITE
  - byte/half store -> RMW_RD
- LOAD: mem_en=1, mem_we=0. Capture the selected lane of mem_do, extended per uns/size, into rdata. Go to RESP.
- RMW_RD: mem_en=1, mem_we=0. Capture mem_do into a merge register. Go to WRITE.
- WRITE: mem_en=1, mem_we=1. mem_di is either wdata (word store) or the merge register with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. rdata holds its value until the next load completes. Stores leave rdata unchanged.
- mem_en=0 in IDLE and RESP. mem_we is high only in WRITE.
- Latency from accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: one request per latency+1 cycles. No accept occurs in RESP.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. Handling depends on the optional feature below.
- mem_addr is driven from the latched address and is stable across all cycles of a request.

Optional Feature:
MEM_ACCESS_MISALIGN_TRAP_EN
- Defined: a misaligned request goes IDLE -> RESP directly (latency 1). There is no memory cycle, resp_err=1 and rdata is unchanged.
- Not defined: resp_err is tied 0. Misaligned addresses are force-aligned (halfword clears addr[0], word clears addr[1:0]) and the access proceeds normally.

Test Plan:
- Reset then idle: after rst_n high -> ready=1, mem_en=0, resp_valid=0. Assert rst_n=0 during WRITE -> mem_we drops the same cycle, no resp_valid follows.
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> mem_we pulses once with mem_addr=4; resp_valid 2 cycles after accept; rdata=0xDEADBEEF.
- Memory word at 0x20 = 0x11223344; byte store 0xAA at addr 0x21 -> RMW_RD then WRITE with mem_di=0x1122AA44; resp_valid 3 cycles after accept.
- Memory word = 0x80FF7F01 at 0x30:
  - lb 0x32 -> rdata=0xFFFFFFFF
  - lbu 0x32 -> 0x000000FF
  - lh 0x32 -> 0xFFFF80FF
  - lhu 0x30 -> 0x00007F01
- Halfword load at 0x31 -> with MEM_ACCESS_MISALIGN_TRAP_EN: resp_valid and resp_err=1 one cycle after accept, mem_en never high. Without the macro: reads the halfword at 0x30, resp_err=0.
- req held high continuously with alternating loads and stores -> each request accepted only when ready=1. No request is lost or duplicated, and responses come back in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory. Sub-word stores are done as read-modify-write.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 30,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    output logic                      ready,
    input  logic                      we,
    input  logic [1:0]                size,
    input  logic                      uns,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic                      resp_valid,
    output logic                      resp_err,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_di,
    input  logic [DATA_WIDTH-1:0]     mem_do
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  l_size;
    logic        l_uns;
    logic [1:0]  l_lane;
    logic [15:0] l_wdata;

    logic        is_word;
    logic [1:0]  acc_lane;
    logic        trap;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;

    assign ready   = (state == IDLE);
    assign is_word = size[1];

    // Lane is force-aligned for the access width; the word address is unaffected.
    always_comb begin
        acc_lane = 2'b00;
        case (size)
            2'b00:   acc_lane = addr[1:0];
            2'b01:   acc_lane = {addr[1], 1'b0};
            default: acc_lane = 2'b00;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        byte_sel = mem_do[{l_lane, 3'b000} +: 8];
        half_sel = mem_do[{l_lane[1], 4'b0000} +: 16];
        case (l_size)
            2'b00:   load_val = l_uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = l_uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_do;
        endcase
    end

    always_comb begin
        merged = mem_do;
        if (l_size == 2'b00)
            merged[{l_lane, 3'b000} +: 8] = l_wdata[7:0];
        else
            merged[{l_lane[1], 4'b0000} +: 16] = l_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            l_size     <= '0;
            l_uns      <= 1'b0;
            l_lane     <= '0;
            l_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_di     <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        l_size   <= size;
                        l_uns    <= uns;
                        l_lane   <= acc_lane;
                        l_wdata  <= wdata[15:0];
                        mem_addr <= addr[ADDR_WIDTH-1:2];
                        if (trap) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!we) begin
                            state  <= LOAD;
                            mem_en <= 1'b1;
                        end else if (is_word) begin
                            state  <= WRITE;
                            mem_en <= 1'b1;
                            mem_we <= 1'b1;
                            mem_di <= wdata;
                        end else begin
                            state  <= RMW_RD;
                            mem_en <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rdata      <= load_val;
                    mem_en     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_di <= merged;
                    mem_we <= 1'b1;
                    state  <= WRITE;
                end
                WRITE: begin
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_err <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural data memory.
// Expectations follow MEM_ACCESS_MISALIGN_TRAP_EN when it is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int          errors = 0;
    int          checks = 0;
    int          lat;
    int          we_cnt;
    logic        en_seen;
    logic        got_err;
    logic [29:0] wa;
    logic [31:0] wd;

    mem_access_unit #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(30), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .we(we), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    assign mem_do = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we)
            mem[mem_addr[5:0]] <= mem_di;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One request from IDLE; records latency (0 = timed out), write activity and resp_err.
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
        logic rv;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; we_cnt = 0; en_seen = 1'b0; got_err = 1'b0; rv = 1'b0; wa = '0; wd = '0;
        for (int i = 1; i <= 8 && !rv; i++) begin
            @(negedge clk);
            if (mem_en) en_seen = 1'b1;
            if (mem_we) begin we_cnt++; wa = mem_addr; wd = mem_di; end
            if (resp_valid) begin rv = 1'b1; lat = i; got_err = resp_err; end
        end
    endtask

    initial begin
        logic        acc_now;
        int          k;
        int          nresp;
        int          quiet;
        logic [31:0] rlog [4];
        logic        seq_we [4];
        logic [31:0] seq_addr [4];
        logic [31:0] seq_data [4];

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", rdata, 32'h0);

        preload(6'd16, 32'h0);
        preload(6'd8, 32'h11223344);
        preload(6'd12, 32'h80FF7F01);

        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_latency", lat, 2);
        check("sw_we_pulses", we_cnt, 1);
        check("sw_mem_addr", 32'(wa), 32'd4);
        check("sw_mem_di", wd, 32'hDEADBEEF);

        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_latency", lat, 2);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_no_write", we_cnt, 0);

        xact(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
        check("sb_latency", lat, 3);
        check("sb_mem_di", wd, 32'h1122AA44);
        check("sb_we_pulses", we_cnt, 1);
        check("sb_rdata_kept", rdata, 32'hDEADBEEF);

        xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
        check("sh_latency", lat, 3);
        check("sh_mem_di", wd, 32'hBEEFAA44);

        xact(1'b0, 2'b00, 1'b0, 32'h32, 32'h0);
        check("lb_rdata", rdata, 32'hFFFFFFFF);
        xact(1'b0, 2'b00, 1'b1, 32'h32, 32'h0);
        check("lbu_rdata", rdata, 32'h000000FF);
        xact(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
        check("lh_rdata", rdata, 32'hFFFF80FF);
        xact(1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
        check("lhu_rdata", rdata, 32'h00007F01);
        xact(1'b0, 2'b00, 1'b1, 32'h31, 32'h0);
        check("lbu_lane1", rdata, 32'h0000007F);

        xact(1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("mis_latency", lat, 1);
        check("mis_err", 32'(got_err), 32'd1);
        check("mis_no_mem", 32'(en_seen), 32'd0);
        check("mis_rdata_kept", rdata, 32'h0000007F);
`else
        check("mis_latency", lat, 2);
        check("mis_err", 32'(got_err), 32'd0);
        check("mis_rdata", rdata, 32'h00007F01);
`endif

        // Reset asserted while the WRITE cycle is in flight.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        check("rstw_in_write", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_we_drop", 32'(mem_we), 32'd0);
        check("rstw_en_drop", 32'(mem_en), 32'd0);
        check("rstw_ready", 32'(ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) quiet++;
        end
        check("rstw_no_resp", quiet, 0);
        check("rstw_mem_untouched", mem[16], 32'h0);
        check("rstw_rdata_cleared", rdata, 32'h0);

        // req held high across alternating stores and loads.
        seq_we[0] = 1'b1; seq_addr[0] = 32'h50; seq_data[0] = 32'hA5A5_0001;
        seq_we[1] = 1'b0; seq_addr[1] = 32'h50; seq_data[1] = 32'h0;
        seq_we[2] = 1'b1; seq_addr[2] = 32'h54; seq_data[2] = 32'h5A5A_0002;
        seq_we[3] = 1'b0; seq_addr[3] = 32'h54; seq_data[3] = 32'h0;
        k = 0; nresp = 0;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                rlog[nresp] = rdata;
                nresp++;
            end
            if (k < 4) begin
                req = 1'b1; we = seq_we[k]; size = 2'b10; uns = 1'b0;
                addr = seq_addr[k]; wdata = seq_data[k];
            end else begin
                req = 1'b0;
            end
            acc_now = ready && req;
            @(posedge clk);
            if (acc_now) k++;
        end
        req = 1'b0;
        check("b2b_accepts", k, 4);
        check("b2b_responses", nresp, 4);
        check("b2b_resp0", rlog[0], 32'h0);
        check("b2b_resp1", rlog[1], 32'hA5A5_0001);
        check("b2b_resp2", rlog[2], 32'hA5A5_0001);
        check("b2b_resp3", rlog[3], 32'h5A5A_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
